// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between execute and the register file.
// Drains one entry per cycle to the write port and forwards pending values to decode.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_stall,
  output logic                     writeEnable,
  output logic [ADDR_W-1:0]        writeAddr,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        qaddr_a,
  input  logic [ADDR_W-1:0]        qaddr_b,
  output logic                     fwd_hit_a,
  output logic [DATA_W-1:0]        fwd_data_a,
  output logic                     fwd_hit_b,
  output logic [DATA_W-1:0]        fwd_data_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic not_empty, pop, accept, push;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & ~wb_stall;
  assign in_ready  = (count_q < CNT_W'(DEPTH)) | pop;
  assign accept    = in_valid & in_ready;
  // x0 results complete the handshake but are dropped here
  assign push      = accept & (in_addr != '0);

  assign writeEnable = pop;
  assign writeAddr   = not_empty ? addr_q[rd_ptr_q] : '0;
  assign writeData   = not_empty ? data_q[rd_ptr_q] : '0;
  assign count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    // Clear before set so a full queue can pop and push the same slot
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = in_addr;
      data_d[wr_ptr_q]  = in_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Walk oldest to youngest so the last match is the youngest pending write
  logic [PTR_W-1:0] idx;
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == qaddr_a) && (qaddr_a != '0)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx] == qaddr_b) && (qaddr_b != '0)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, latency, ordering, forwarding, x0, full+pop.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  qaddr_a, qaddr_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  regfile_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_stall(wb_stall),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .qaddr_a(qaddr_a), .qaddr_b(qaddr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count)
  );

  always #5 clk = ~clk;

  // Inputs are set just after a negedge; record any commit, then move to the next negedge.
  task automatic tick();
    #1;
    if (writeEnable) begin
      log_addr.push_back(writeAddr);
      log_data.push_back(writeData);
    end
    @(negedge clk);
  endtask

  task automatic push_tick(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", writeEnable); end
    n_checks++; if (writeAddr !== 5'd0 || writeData !== 32'd0) begin n_fail++; $display("FAIL reset_wport: got %0d/%h want 0/0", writeAddr, writeData); end
    n_checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'd0) begin n_fail++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwd_hit_a, fwd_data_a); end
    @(negedge clk);
    rst = 1'b0;
    // queue three entries under stall, then reset with the head about to commit
    wb_stall = 1'b1;
    push_tick(5'd1, 32'h1);
    push_tick(5'd2, 32'h2);
    push_tick(5'd3, 32'h3);
    wb_stall = 1'b0;
    #1;
    n_checks++; if (count !== 3'd3 || writeEnable !== 1'b1) begin n_fail++; $display("FAIL prereset_state: got cnt=%0d we=%b want 3/1", count, writeEnable); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
    n_checks++; if (writeEnable !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", writeEnable); end
    @(negedge clk);
    rst = 1'b0;
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL postreset_writes: got %0d writes want 0", log_addr.size()); end
  endtask

  task automatic test_single();
    log_addr.delete(); log_data.delete();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (in_ready !== 1'b1 || writeEnable !== 1'b0) begin n_fail++; $display("FAIL single_pre: got rdy=%b we=%b want 1/0", in_ready, writeEnable); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (writeEnable !== 1'b1 || writeAddr !== 5'd5 || writeData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_wport: got we=%b a=%0d d=%h want 1/5/deadbeef", writeEnable, writeAddr, writeData); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_cnt1: got %0d want 1", count); end
    tick();
    #1;
    n_checks++; if (count !== 3'd0 || writeEnable !== 1'b0) begin n_fail++; $display("FAIL single_drained: got cnt=%0d we=%b want 0/0", count, writeEnable); end
    n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL single_nwrites: got %0d want 1", log_addr.size()); end
  endtask

  task automatic test_stall_order();
    log_addr.delete(); log_data.delete();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_tick(5'(i), 32'h100 + 32'(i));
    #1;
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full: got cnt=%0d rdy=%b want 4/0", count, in_ready); end
    n_checks++; if (writeEnable !== 1'b0) begin n_fail++; $display("FAIL stall_we: got %b want 0", writeEnable); end
    wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++; if (writeEnable !== 1'b1 || writeAddr !== 5'(i)) begin
        n_fail++; $display("FAIL stall_drain%0d: got we=%b a=%0d want 1/%0d", i, writeEnable, writeAddr, i); end
      tick();
    end
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stall_empty: got %0d want 0", count); end
    n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL stall_nwrites: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_checks++; if (log_addr[i] !== 5'(i + 1) || log_data[i] !== 32'h101 + 32'(i)) begin
        n_fail++; $display("FAIL stall_log%0d: got %0d/%h want %0d/%h", i, log_addr[i], log_data[i], i + 1, 32'h101 + 32'(i)); end
    end
  endtask

  task automatic test_forward();
    log_addr.delete(); log_data.delete();
    wb_stall = 1'b1;
    push_tick(5'd7, 32'h11);
    push_tick(5'd7, 32'h22);
    push_tick(5'd3, 32'h33);
    qaddr_a = 5'd7; qaddr_b = 5'd8;
    #1;
    n_checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h22) begin n_fail++; $display("FAIL fwd_a_young: got %b/%h want 1/22", fwd_hit_a, fwd_data_a); end
    n_checks++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'h0) begin n_fail++; $display("FAIL fwd_b_miss: got %b/%h want 0/0", fwd_hit_b, fwd_data_b); end
    qaddr_b = 5'd3;
    #1;
    n_checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 32'h33) begin n_fail++; $display("FAIL fwd_b_hit: got %b/%h want 1/33", fwd_hit_b, fwd_data_b); end
    // pop the first r7; the second one still forwards
    wb_stall = 1'b0;
    tick();
    wb_stall = 1'b1;
    #1;
    n_checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h22 || count !== 3'd2) begin
      n_fail++; $display("FAIL fwd_after_pop: got %b/%h cnt=%0d want 1/22/2", fwd_hit_a, fwd_data_a, count); end
    // head (r7,0x22) being written this cycle still counts as a hit
    wb_stall = 1'b0;
    #1;
    n_checks++; if (writeEnable !== 1'b1 || fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h22) begin
      n_fail++; $display("FAIL fwd_head_writing: got we=%b %b/%h want 1/1/22", writeEnable, fwd_hit_a, fwd_data_a); end
    tick();
    #1;
    n_checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'h0) begin n_fail++; $display("FAIL fwd_a_gone: got %b/%h want 0/0", fwd_hit_a, fwd_data_a); end
    tick();
    n_checks++; if (log_addr.size() != 3 || log_data[0] !== 32'h11 || log_data[1] !== 32'h22 || log_addr[2] !== 5'd3) begin
      n_fail++; $display("FAIL fwd_log: got %0d writes want 7/11,7/22,3/33", log_addr.size()); end
    qaddr_a = 5'd0; qaddr_b = 5'd0;
  endtask

  task automatic test_x0();
    log_addr.delete(); log_data.delete();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    qaddr_a = 5'd0;
    #1;
    n_checks++; if (count !== 3'd0 || writeEnable !== 1'b0) begin n_fail++; $display("FAIL x0_cnt: got cnt=%0d we=%b want 0/0", count, writeEnable); end
    n_checks++; if (fwd_hit_a !== 1'b0) begin n_fail++; $display("FAIL x0_fwd: got %b want 0", fwd_hit_a); end
    tick(); tick();
    n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL x0_writes: got %0d want 0", log_addr.size()); end
  endtask

  task automatic test_full_pop();
    log_addr.delete(); log_data.delete();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_tick(5'd10 + 5'(i), 32'hA0 + 32'(i));
    wb_stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
    #1;
    n_checks++; if (in_ready !== 1'b1 || writeEnable !== 1'b1 || writeAddr !== 5'd10) begin
      n_fail++; $display("FAIL full_push_rdy: got rdy=%b we=%b a=%0d want 1/1/10", in_ready, writeEnable, writeAddr); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_push_cnt: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", count); end
    n_checks++; if (log_addr.size() != 5) begin n_fail++; $display("FAIL full_nwrites: got %0d want 5", log_addr.size()); end
    else begin
      n_checks++; if (log_addr[4] !== 5'd9 || log_data[4] !== 32'h99) begin
        n_fail++; $display("FAIL full_r9_last: got %0d/%h want 9/99", log_addr[4], log_data[4]); end
      n_checks++; if (log_addr[1] !== 5'd11 || log_addr[3] !== 5'd13) begin
        n_fail++; $display("FAIL full_order: got %0d,%0d want 11,13", log_addr[1], log_addr[3]); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wb_stall = 1'b0; qaddr_a = '0; qaddr_b = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stall_order();
    test_forward();
    test_x0();
    test_full_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
